// File: rtl/pwm_capture.sv
// Measures period and active time of an asynchronous PWM input in clk cycles; continuous mode.
// Latency: SYNC_STAGES+1 clk edges from raw edge to registered result; no backpressure, valid is a pulse.
module pwm_capture #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             polarity,
   input  logic             clr,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] duty_cycle,
   output logic             valid,
   output logic             overflow,
   output logic             level,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_prev_q;
   logic                   en_q;
   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       cnt_p_q, cnt_p_d;
   logic [WIDTH-1:0]       cnt_h_q, cnt_h_d;
   logic [WIDTH-1:0]       period_q, period_d;
   logic [WIDTH-1:0]       duty_q, duty_d;
   logic                   valid_q, valid_d;
   logic                   overflow_q, overflow_d;
   logic                   s;
   logic                   act_edge;
   logic                   timeout;

   assign s        = sync_q[SYNC_STAGES-1] ^ polarity;
   assign act_edge = s & ~s_prev_q;

   always_comb begin
      state_d  = state_q;
      cnt_p_d  = cnt_p_q;
      cnt_h_d  = cnt_h_q;
      period_d = period_q;
      duty_d   = duty_q;
      valid_d  = 1'b0;
      timeout  = 1'b0;
      if (!en) begin
         state_d = IDLE;
         cnt_p_d = '0;
         cnt_h_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = ARM;
               cnt_p_d = '0;
               cnt_h_d = '0;
            end
            ARM: begin
               // Anything seen before the first active edge is a partial period.
               if (act_edge) begin
                  state_d = MEAS;
                  cnt_p_d = CNT_ONE;
                  cnt_h_d = CNT_ONE;
               end else begin
                  cnt_p_d = '0;
                  cnt_h_d = '0;
               end
            end
            MEAS: begin
               if (act_edge) begin
                  period_d = cnt_p_q;
                  duty_d   = cnt_h_q;
                  valid_d  = 1'b1;
                  cnt_p_d  = CNT_ONE;
                  cnt_h_d  = CNT_ONE;
               end else if (cnt_p_q == CNT_MAX) begin
                  timeout  = 1'b1;
                  period_d = '0;
                  duty_d   = '0;
                  valid_d  = 1'b1;
                  cnt_p_d  = '0;
                  cnt_h_d  = '0;
                  state_d  = ARM;
               end else begin
                  cnt_p_d = cnt_p_q + CNT_ONE;
                  if (s && (cnt_h_q != CNT_MAX)) begin
                     cnt_h_d = cnt_h_q + CNT_ONE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_p_d = '0;
               cnt_h_d = '0;
            end
         endcase
      end
   end

   // A timeout in the same cycle as a clear leaves the flag set.
   always_comb begin
      overflow_d = overflow_q;
      if (clr || (en && !en_q)) begin
         overflow_d = 1'b0;
      end
      if (timeout) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         s_prev_q   <= 1'b0;
         en_q       <= 1'b0;
         state_q    <= IDLE;
         cnt_p_q    <= '0;
         cnt_h_q    <= '0;
         period_q   <= '0;
         duty_q     <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         s_prev_q   <= s;
         en_q       <= en;
         state_q    <= state_d;
         cnt_p_q    <= cnt_p_d;
         cnt_h_q    <= cnt_h_d;
         period_q   <= period_d;
         duty_q     <= duty_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
      end
   end

   assign period     = period_q;
   assign duty_cycle = duty_q;
   assign valid      = valid_q;
   assign overflow   = overflow_q;
   assign level      = s_prev_q;
   assign state      = state_q;

endmodule
